memory_bus_bridge: RTL and testbench

Bridges the core's simple memory port (`mem_rd_en`/`mem_wr_en`/`mem_busy`) to a Wishbone B4 classic master interface toward the system interconnect. Sits directly downstream of `core`: it captures one request at a time, runs one Wishbone cycle, returns read data and releases `mem_busy` on completion. A watchdog terminates unacknowledged cycles and reports a bus error.

---
 rtl/memory_bus_bridge_if.sv | 31 +++
 rtl/memory_bus_bridge.sv | 110 +++++++++++
 tb/tb_memory_bus_bridge.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_bus_bridge_if.sv
// Wishbone B4 classic bus bundle between memory_bus_bridge (master) and the
// system interconnect (slave).
//
// Handshake: the master holds cyc_o/stb_o high together with stable we_o,
// adr_o, dat_o and sel_o until the slave terminates the transfer. A transfer
// ends in the cycle where the slave drives ack_i (success) or err_i (failure)
// high while stb_o is high; err_i wins if both are seen. Terminations seen
// while stb_o is low carry no meaning and are ignored by the master.
interface memory_bus_bridge_if #(
    parameter int DATA_SIZE = 32
);
    logic                   cyc_o;
    logic                   stb_o;
    logic                   we_o;
    logic [DATA_SIZE-1:0]   adr_o;
    logic [DATA_SIZE-1:0]   dat_o;
    logic [DATA_SIZE/8-1:0] sel_o;
    logic [DATA_SIZE-1:0]   dat_i;
    logic                   ack_i;
    logic                   err_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        output dat_i, ack_i, err_i
    );
endinterface

// File: rtl/memory_bus_bridge.sv
// memory_bus_bridge: turns the core's level-style memory request into one
// Wishbone classic cycle at a time, returns load data, and reports a bus
// error when the slave signals err_i or never answers within TIMEOUT_CYCLES.
module memory_bus_bridge #(
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_SIZE-1:0]   mem_addr,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic                   mem_rd_en,
    input  logic                   mem_wr_en,
    input  logic [DATA_SIZE/8-1:0] mem_byte_en,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   mem_busy,
    output logic                   bus_error,
    output logic [1:0]             state_dbg,
    memory_bus_bridge_if.master    wb
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter value of the final BUS cycle before the watchdog fires.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] tmo_cnt;
    logic        req;
    logic        fail;

    assign req       = mem_rd_en | mem_wr_en;
    assign state_dbg = state;

    // The bus cycle fails on err_i, or on a silent slave at the last allowed cycle.
    assign fail = wb.err_i | (~wb.ack_i & (tmo_cnt == TMO_LAST));

    // Busy must rise in the same cycle the request appears, so the core never
    // samples a stale not-busy before the FSM has left IDLE.
    assign mem_busy = ((state == S_IDLE) & req) | (state == S_BUS);

    // Main FSM: capture request, run one Wishbone cycle, report completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            rd_data   <= '0;
            bus_error <= 1'b0;
            wb.cyc_o  <= 1'b0;
            wb.stb_o  <= 1'b0;
            wb.we_o   <= 1'b0;
            wb.adr_o  <= '0;
            wb.dat_o  <= '0;
            wb.sel_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus_error <= 1'b0;
                    if (req) begin
                        // A store takes precedence when both enables are high.
                        wb.we_o  <= mem_wr_en;
                        wb.adr_o <= mem_addr;
                        wb.dat_o <= wr_data;
                        wb.sel_o <= mem_byte_en;
                        wb.cyc_o <= 1'b1;
                        wb.stb_o <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (fail) begin
                        bus_error <= 1'b1;
                        if (!wb.we_o) begin
                            rd_data <= '1;
                        end
                        wb.cyc_o <= 1'b0;
                        wb.stb_o <= 1'b0;
                        state    <= S_DONE;
                    end else if (wb.ack_i) begin
                        if (!wb.we_o) begin
                            rd_data <= wb.dat_i;
                        end
                        wb.cyc_o <= 1'b0;
                        wb.stb_o <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    // Error pulse lasts only for the DONE cycle.
                    bus_error <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    bus_error <= 1'b0;
                    wb.cyc_o  <= 1'b0;
                    wb.stb_o  <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_bridge.sv
// Testbench for memory_bus_bridge: emulates the core and a Wishbone slave,
// with expected load data and error flags kept in a scoreboard queue.
module tb_memory_bus_bridge;

    localparam int DW = 32;

    logic            clock;
    logic            reset;
    logic [DW-1:0]   mem_addr;
    logic [DW-1:0]   wr_data;
    logic            mem_rd_en;
    logic            mem_wr_en;
    logic [DW/8-1:0] mem_byte_en;
    logic [DW-1:0]   rd_data;
    logic            mem_busy;
    logic            bus_error;
    logic [1:0]      state_dbg;

    memory_bus_bridge_if #(.DATA_SIZE(DW)) wb ();

    memory_bus_bridge #(
        .DATA_SIZE      (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .wr_data     (wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_byte_en (mem_byte_en),
        .rd_data     (rd_data),
        .mem_busy    (mem_busy),
        .bus_error   (bus_error),
        .state_dbg   (state_dbg),
        .wb          (wb)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic          exp_err_q[$];
    logic [DW-1:0] last_rd;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    int            total;
    int            bad;

    // run_bus results
    int            n_stb;
    logic          timed_out;
    logic          changed;
    logic          s_we;
    logic [DW-1:0] s_adr;
    logic [DW-1:0] s_dat;
    logic [3:0]    s_sel;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [DW-1:0] a,
                             input logic [DW-1:0] d, input logic [3:0] be);
        mem_rd_en   = rd;
        mem_wr_en   = wr;
        mem_addr    = a;
        wr_data     = d;
        mem_byte_en = be;
    endtask

    task automatic drop_req();
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
    endtask

    // Wishbone slave: called at the start of the first stb cycle; answers on
    // stb cycle ack_at / err_at (0 = never) and returns at the DONE negedge.
    task automatic run_bus(input int ack_at, input int err_at, input logic [DW-1:0] rdata,
                           output int ns, output logic to, output logic chg,
                           output logic we, output logic [DW-1:0] adr,
                           output logic [DW-1:0] dat, output logic [3:0] sel);
        ns = 0; to = 1'b1; chg = 1'b0;
        we = 1'b0; adr = '0; dat = '0; sel = '0;
        for (int k = 1; k <= 40; k++) begin
            wb.ack_i = (k == ack_at);
            wb.err_i = (k == err_at);
            wb.dat_i = rdata;
            @(negedge clock);
            if (!wb.stb_o && !mem_busy) begin
                to = 1'b0;
                break;
            end
            if (wb.stb_o) begin
                if (ns == 0) begin
                    we = wb.we_o; adr = wb.adr_o; dat = wb.dat_o; sel = wb.sel_o;
                end else if ({wb.we_o, wb.adr_o, wb.dat_o, wb.sel_o} !== {we, adr, dat, sel}) begin
                    chg = 1'b1;
                end
                ns++;
            end
            @(posedge clock);
            #1;
        end
        wb.ack_i = 1'b0;
        wb.err_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drop_req();
        mem_addr = '0; wr_data = '0; mem_byte_en = '0;
        wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.dat_i = '0;
        step();
        step();
        @(negedge clock);
        total++;
        if ({wb.cyc_o, wb.stb_o, wb.we_o} !== 3'b000) begin
            bad++; $display("FAIL reset_ctl: got %b want 000", {wb.cyc_o, wb.stb_o, wb.we_o});
        end
        total++;
        if ({wb.adr_o, wb.dat_o, wb.sel_o} !== '0) begin
            bad++; $display("FAIL reset_bus: adr=%h dat=%h sel=%b want zeros", wb.adr_o, wb.dat_o, wb.sel_o);
        end
        total++;
        if ({rd_data, mem_busy, bus_error, state_dbg} !== '0) begin
            bad++; $display("FAIL reset_core: rd=%h busy=%b err=%b st=%0d want all 0",
                            rd_data, mem_busy, bus_error, state_dbg);
        end
        last_rd = '0;
        // Release reset and wave an ack at the idle bridge: it must be ignored.
        step();
        reset = 1'b0;
        wb.ack_i = 1'b1;
        wb.err_i = 1'b1;
        step();
        wb.ack_i = 1'b0;
        wb.err_i = 1'b0;
        @(negedge clock);
        total++;
        if ({wb.cyc_o, wb.stb_o, bus_error, mem_busy, state_dbg} !== 6'b0) begin
            bad++; $display("FAIL idle_ack_ignored: cyc=%b stb=%b err=%b busy=%b st=%0d want 0",
                            wb.cyc_o, wb.stb_o, bus_error, mem_busy, state_dbg);
        end
    endtask

    task automatic test_timeout();
        step();
        drive_req(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
        exp_q.push_back(32'hFFFF_FFFF); exp_err_q.push_back(1'b1); last_rd = 32'hFFFF_FFFF;
        step();
        run_bus(0, 0, 32'h1111_1111, n_stb, timed_out, changed, s_we, s_adr, s_dat, s_sel);
        total++;
        if (timed_out) begin bad++; $display("FAIL tmo_done: no completion seen"); end
        total++;
        if (n_stb !== 4) begin bad++; $display("FAIL tmo_stb_cycles: got %0d want 4", n_stb); end
        exp_rd = exp_q.pop_front(); exp_err = exp_err_q.pop_front();
        total++;
        if (rd_data !== exp_rd) begin bad++; $display("FAIL tmo_rd_data: got %h want %h", rd_data, exp_rd); end
        total++;
        if ({bus_error, mem_busy} !== {exp_err, 1'b0}) begin
            bad++; $display("FAIL tmo_err_busy: got err=%b busy=%b want err=%b busy=0", bus_error, mem_busy, exp_err);
        end
        drop_req();
        step();
        @(negedge clock);
        total++;
        if ({bus_error, state_dbg} !== 3'b000) begin
            bad++; $display("FAIL tmo_pulse_end: got err=%b st=%0d want err=0 st=0", bus_error, state_dbg);
        end
    endtask

    task automatic test_read_zero_wait();
        step();
        drive_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        exp_q.push_back(32'hDEAD_BEEF); exp_err_q.push_back(1'b0); last_rd = 32'hDEAD_BEEF;
        @(negedge clock);
        total++;
        if ({mem_busy, wb.stb_o} !== 2'b10) begin
            bad++; $display("FAIL rd_cycle0: got busy=%b stb=%b want busy=1 stb=0", mem_busy, wb.stb_o);
        end
        step();
        run_bus(1, 0, 32'hDEAD_BEEF, n_stb, timed_out, changed, s_we, s_adr, s_dat, s_sel);
        total++;
        if (timed_out || n_stb !== 1) begin
            bad++; $display("FAIL rd_stb_cycles: got %0d (hung=%b) want 1", n_stb, timed_out);
        end
        total++;
        if ({s_we, s_adr} !== {1'b0, 32'h0000_0100}) begin
            bad++; $display("FAIL rd_bus_fields: got we=%b adr=%h want we=0 adr=00000100", s_we, s_adr);
        end
        exp_rd = exp_q.pop_front(); exp_err = exp_err_q.pop_front();
        total++;
        if (rd_data !== exp_rd) begin bad++; $display("FAIL rd_data: got %h want %h", rd_data, exp_rd); end
        total++;
        if ({bus_error, mem_busy} !== {exp_err, 1'b0}) begin
            bad++; $display("FAIL rd_err_busy: got err=%b busy=%b want err=%b busy=0", bus_error, mem_busy, exp_err);
        end
        drop_req();
        step();
        @(negedge clock);
        total++;
        if ({state_dbg, mem_busy} !== 3'b000) begin
            bad++; $display("FAIL rd_back_idle: got st=%0d busy=%b want 0", state_dbg, mem_busy);
        end
    endtask

    task automatic test_byte_write();
        step();
        drive_req(1'b0, 1'b1, 32'h0000_0203, 32'h0000_00AB, 4'b1000);
        exp_q.push_back(last_rd); exp_err_q.push_back(1'b0);
        step();
        run_bus(4, 0, 32'h7777_7777, n_stb, timed_out, changed, s_we, s_adr, s_dat, s_sel);
        total++;
        if (timed_out || n_stb !== 4) begin
            bad++; $display("FAIL wr_stb_cycles: got %0d (hung=%b) want 4", n_stb, timed_out);
        end
        total++;
        if ({s_we, s_adr, s_dat, s_sel} !== {1'b1, 32'h0000_0203, 32'h0000_00AB, 4'b1000}) begin
            bad++; $display("FAIL wr_bus_fields: got we=%b adr=%h dat=%h sel=%b want 1 00000203 000000ab 1000",
                            s_we, s_adr, s_dat, s_sel);
        end
        total++;
        if (changed) begin bad++; $display("FAIL wr_stable: bus fields changed got 1 want 0"); end
        exp_rd = exp_q.pop_front(); exp_err = exp_err_q.pop_front();
        total++;
        if (rd_data !== exp_rd) begin bad++; $display("FAIL wr_rd_kept: got %h want %h", rd_data, exp_rd); end
        total++;
        if ({bus_error, mem_busy} !== {exp_err, 1'b0}) begin
            bad++; $display("FAIL wr_err_busy: got err=%b busy=%b want err=%b busy=0", bus_error, mem_busy, exp_err);
        end
        drop_req();
    endtask

    task automatic test_error();
        step();
        drive_req(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        exp_q.push_back(32'hFFFF_FFFF); exp_err_q.push_back(1'b1); last_rd = 32'hFFFF_FFFF;
        step();
        run_bus(2, 2, 32'h1234_5678, n_stb, timed_out, changed, s_we, s_adr, s_dat, s_sel);
        total++;
        if (timed_out || n_stb !== 2) begin
            bad++; $display("FAIL err_stb_cycles: got %0d (hung=%b) want 2", n_stb, timed_out);
        end
        exp_rd = exp_q.pop_front(); exp_err = exp_err_q.pop_front();
        total++;
        if (rd_data !== exp_rd) begin bad++; $display("FAIL err_rd_data: got %h want %h", rd_data, exp_rd); end
        total++;
        if (bus_error !== exp_err) begin bad++; $display("FAIL err_flag: got %b want %b", bus_error, exp_err); end
        drop_req();
        step();
        @(negedge clock);
        total++;
        if (bus_error !== 1'b0) begin bad++; $display("FAIL err_pulse_end: got %b want 0", bus_error); end
    endtask

    task automatic test_back_to_back();
        step();
        drive_req(1'b1, 1'b1, 32'h0000_0400, 32'h55AA_55AA, 4'hF);
        exp_q.push_back(last_rd); exp_err_q.push_back(1'b0);
        step();
        run_bus(1, 0, 32'h9999_9999, n_stb, timed_out, changed, s_we, s_adr, s_dat, s_sel);
        total++;
        if (timed_out || {s_we, s_dat} !== {1'b1, 32'h55AA_55AA}) begin
            bad++; $display("FAIL b2b_write_wins: got we=%b dat=%h want we=1 dat=55aa55aa", s_we, s_dat);
        end
        exp_rd = exp_q.pop_front(); exp_err = exp_err_q.pop_front();
        total++;
        if ({rd_data, bus_error, mem_busy} !== {exp_rd, exp_err, 1'b0}) begin
            bad++; $display("FAIL b2b_first_done: got rd=%h err=%b busy=%b want rd=%h err=%b busy=0",
                            rd_data, bus_error, mem_busy, exp_rd, exp_err);
        end
        // Keep the read enable high through DONE with a new address.
        mem_wr_en = 1'b0;
        mem_addr  = 32'h0000_0404;
        exp_q.push_back(32'hCAFE_F00D); exp_err_q.push_back(1'b0); last_rd = 32'hCAFE_F00D;
        step();
        @(negedge clock);
        total++;
        if ({state_dbg, mem_busy} !== 3'b001) begin
            bad++; $display("FAIL b2b_idle_busy: got st=%0d busy=%b want st=0 busy=1", state_dbg, mem_busy);
        end
        step();
        run_bus(1, 0, 32'hCAFE_F00D, n_stb, timed_out, changed, s_we, s_adr, s_dat, s_sel);
        total++;
        if (timed_out || n_stb !== 1 || {s_we, s_adr} !== {1'b0, 32'h0000_0404}) begin
            bad++; $display("FAIL b2b_second_bus: got stb=%0d we=%b adr=%h want 1 0 00000404", n_stb, s_we, s_adr);
        end
        exp_rd = exp_q.pop_front(); exp_err = exp_err_q.pop_front();
        total++;
        if ({rd_data, bus_error} !== {exp_rd, exp_err}) begin
            bad++; $display("FAIL b2b_second_rd: got rd=%h err=%b want rd=%h err=%b", rd_data, bus_error, exp_rd, exp_err);
        end
        drop_req();
    endtask

    task automatic test_reset_mid_bus();
        step();
        drive_req(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
        step();
        @(negedge clock);
        step();
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (wb.stb_o !== 1'b1) begin bad++; $display("FAIL rst_bus2_stb: got %b want 1", wb.stb_o); end
        step();
        drop_req();
        last_rd = '0;
        @(negedge clock);
        total++;
        if ({wb.cyc_o, wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o, wb.sel_o} !== '0) begin
            bad++; $display("FAIL rst_bus_out: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%b want zeros",
                            wb.cyc_o, wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o, wb.sel_o);
        end
        total++;
        if ({rd_data, bus_error, state_dbg} !== {last_rd, 1'b0, 2'd0}) begin
            bad++; $display("FAIL rst_core_out: got rd=%h err=%b st=%0d want 0", rd_data, bus_error, state_dbg);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if ({bus_error, mem_busy, wb.cyc_o} !== 3'b000) begin
                bad++; $display("FAIL rst_no_completion: got err=%b busy=%b cyc=%b want 0",
                                bus_error, mem_busy, wb.cyc_o);
            end
            step();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_timeout();
        test_read_zero_wait();
        test_byte_write();
        test_error();
        test_back_to_back();
        test_reset_mid_bus();
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
